// File: rtl/ballot_controller.sv
// Ballot front end: synchronises and debounces the voter buttons, runs
// officer-authorised single-ballot sessions with a timeout and issues one
// vote strobe per session to the downstream tally block.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | no session; waiting for ballot_open
// S_ARMED    | session open, no candidate selected yet
// S_SELECTED | candidate selected; cast or reselect accepted
// S_CAST     | one-cycle vote strobe to the tally block
// S_LOCKOUT  | vote issued; wait for every button to be released
module ballot_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int TMR_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ballot_open,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic       btn_c,
  input  logic       btn_cast,
  output logic [1:0] vote_input,
  output logic       vote_enable,
  output logic       ready,
  output logic [1:0] selection,
  output logic       timeout_pulse,
  output logic       invalid_pulse,
  output logic [7:0] ballots_cast
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  // Timer is a down-counter; expiry at zero lands exactly when the elapsed
  // count since arming (or the last accepted press) reaches TIMEOUT_CYCLES-1.
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_SELECTED,
    S_CAST,
    S_LOCKOUT
  } state_t;

  state_t          state;
  logic [TMR_W-1:0] tmr;
  logic [3:0]      btn_raw;
  logic [3:0]      sync1;
  logic [3:0]      sync2;
  logic [3:0]      deb;
  logic [3:0]      press;
  logic [DB_W-1:0] db_cnt [4];
  logic            cand_multi;
  logic            cand_single;
  logic [1:0]      cand_code;

  // bit order: 0=A, 1=B, 2=C, 3=cast
  assign btn_raw = {btn_cast, btn_c, btn_b, btn_a};

  // Two-flop synchroniser for the asynchronous buttons
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Debounce: level follows after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Press = debounced level about to rise; coincides with the debounced edge
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      press[i] = sync2[i] & ~deb[i] & (db_cnt[i] == DB_LAST);
    end
  end

  // Classify candidate presses landing in the same cycle
  always_comb begin
    cand_multi  = (press[0] & press[1]) | (press[0] & press[2]) | (press[1] & press[2]);
    cand_single = (|press[2:0]) & ~cand_multi;
    if (press[0])      cand_code = 2'b00;
    else if (press[1]) cand_code = 2'b01;
    else               cand_code = 2'b10;
  end

  // Session FSM with registered outputs and inactivity timer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      tmr           <= '0;
      vote_input    <= 2'b11;
      vote_enable   <= 1'b0;
      ready         <= 1'b0;
      selection     <= 2'b11;
      timeout_pulse <= 1'b0;
      invalid_pulse <= 1'b0;
      ballots_cast  <= '0;
    end else begin
      vote_enable   <= 1'b0;
      vote_input    <= 2'b11;
      timeout_pulse <= 1'b0;
      invalid_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ballot_open) begin
            state <= S_ARMED;
            ready <= 1'b1;
            tmr   <= TMR_LOAD;
          end else begin
            tmr <= '0;
          end
        end
        S_ARMED, S_SELECTED: begin
          if ((state == S_SELECTED) && press[3]) begin
            // cast beats a simultaneous candidate press; old selection is voted
            state        <= S_CAST;
            ready        <= 1'b0;
            vote_enable  <= 1'b1;
            vote_input   <= selection;
            ballots_cast <= ballots_cast + 8'd1;
          end else if (cand_single) begin
            state     <= S_SELECTED;
            selection <= cand_code;
            tmr       <= TMR_LOAD;
          end else begin
            invalid_pulse <= cand_multi;
            if (tmr == '0) begin
              timeout_pulse <= 1'b1;
              selection     <= 2'b11;
              ready         <= 1'b0;
              state         <= S_IDLE;
            end else begin
              tmr <= tmr - TMR_W'(1);
            end
          end
        end
        S_CAST: begin
          state <= S_LOCKOUT;
        end
        S_LOCKOUT: begin
          if (deb == 4'b0000) begin
            state     <= S_IDLE;
            selection <= 2'b11;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ballot_controller.sv
// Self-checking bench for ballot_controller. The reference model treats a
// button's debounced level as "the last DEBOUNCE_CYCLES synchronised samples
// all disagree with it", and a session as voting/casting/locked phases with
// an elapsed-cycle count, compared against the DUT every cycle.
module tb_ballot_controller;

  localparam int D = 4;
  localparam int T = 20;
  localparam logic [15:0] RST_VEC = 16'hCC00;
  localparam int PH_IDLE    = 0;
  localparam int PH_VOTING  = 1;
  localparam int PH_CASTING = 2;
  localparam int PH_LOCKED  = 3;

  logic clk = 1'b0;
  logic reset, ballot_open, btn_a, btn_b, btn_c, btn_cast;
  logic [1:0] vote_input, selection;
  logic vote_enable, ready, timeout_pulse, invalid_pulse;
  logic [7:0] ballots_cast;

  int vectors = 0;
  int miscompares = 0;

  bit [3:0] hist [0:D];
  bit [3:0] m_deb;
  int m_ph, m_since;
  logic [1:0] m_vin, m_sel;
  logic m_ven, m_ready, m_to, m_inv;
  logic [7:0] m_cnt;

  ballot_controller #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T), .TMR_W(16)) dut (
    .clk(clk), .reset(reset), .ballot_open(ballot_open),
    .btn_a(btn_a), .btn_b(btn_b), .btn_c(btn_c), .btn_cast(btn_cast),
    .vote_input(vote_input), .vote_enable(vote_enable), .ready(ready),
    .selection(selection), .timeout_pulse(timeout_pulse),
    .invalid_pulse(invalid_pulse), .ballots_cast(ballots_cast)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] dut_vec();
    return {vote_input, vote_enable, ready, selection, timeout_pulse, invalid_pulse, ballots_cast};
  endfunction

  function automatic logic [15:0] mdl_vec();
    return {m_vin, m_ven, m_ready, m_sel, m_to, m_inv, m_cnt};
  endfunction

  task automatic model_reset();
    for (int j = 0; j <= D; j++) hist[j] = '0;
    m_deb = '0; m_ph = PH_IDLE; m_since = 0;
    m_vin = 2'b11; m_sel = 2'b11; m_ven = 0; m_ready = 0; m_to = 0; m_inv = 0;
    m_cnt = '0;
  endtask

  task automatic model_edge(input bit [3:0] raw, input bit open);
    bit [3:0] deb_old;
    bit [3:0] press;
    bit all_diff;
    int n;
    logic [1:0] code;
    deb_old = m_deb;
    press = '0;
    for (int i = 0; i < 4; i++) begin
      all_diff = 1;
      for (int j = 1; j <= D; j++) if (hist[j][i] == m_deb[i]) all_diff = 0;
      if (all_diff) begin
        m_deb[i] = ~m_deb[i];
        press[i] = m_deb[i];
      end
    end
    for (int j = D; j >= 1; j--) hist[j] = hist[j-1];
    hist[0] = raw;
    n = int'(press[0]) + int'(press[1]) + int'(press[2]);
    code = press[0] ? 2'd0 : (press[1] ? 2'd1 : 2'd2);
    m_ven = 0; m_vin = 2'b11; m_to = 0; m_inv = 0;
    case (m_ph)
      PH_IDLE: if (open) begin m_ph = PH_VOTING; m_ready = 1; m_since = 0; end
      PH_VOTING: begin
        if (m_sel != 2'b11 && press[3]) begin
          m_ph = PH_CASTING; m_ready = 0; m_ven = 1; m_vin = m_sel; m_cnt = m_cnt + 8'd1;
        end else if (n == 1) begin
          m_sel = code; m_since = 0;
        end else begin
          m_inv = (n > 1);
          m_since++;
          if (m_since == T - 1) begin
            m_to = 1; m_sel = 2'b11; m_ready = 0; m_ph = PH_IDLE;
          end
        end
      end
      PH_CASTING: m_ph = PH_LOCKED;
      default: if (deb_old == 4'b0000) begin m_ph = PH_IDLE; m_sel = 2'b11; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge({btn_cast, btn_c, btn_b, btn_a}, ballot_open);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] b);
    {btn_cast, btn_c, btn_b, btn_a} = b;
  endtask

  task automatic test_reset();
    reset = 1; ballot_open = 0; drive(4'b0000);
    tick(); tick();
    vectors++;
    if (dut_vec() !== RST_VEC) begin miscompares++; $display("FAIL reset_state got %h want %h", dut_vec(), RST_VEC); end
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (dut_vec() !== mdl_vec() || dut_vec() !== RST_VEC) begin
        miscompares++; $display("FAIL reset_idle got %h want %h", dut_vec(), RST_VEC);
      end
    end
  endtask

  task automatic test_basic_vote();
    int n, votes;
    ballot_open = 1; tick(); ballot_open = 0;
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL basic_arm ready got %b want 1", ready); end
    tick(); tick();
    drive(4'b0010);
    n = 0;
    while (selection !== 2'b01 && n < 20) begin
      tick(); n++;
      vectors++; if (dut_vec() !== mdl_vec()) begin miscompares++; $display("FAIL basic_select t=%0t got %h want %h", $time, dut_vec(), mdl_vec()); end
    end
    vectors++; if (n != 2 + D) begin miscompares++; $display("FAIL select_latency got %0d want %0d", n, 2 + D); end
    drive(4'b1010);
    votes = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (vote_enable === 1'b1) begin
        votes++;
        vectors++; if (vote_input !== 2'b01) begin miscompares++; $display("FAIL basic_vote_input got %b want 01", vote_input); end
      end
      vectors++; if (dut_vec() !== mdl_vec()) begin miscompares++; $display("FAIL basic_cast t=%0t got %h want %h", $time, dut_vec(), mdl_vec()); end
    end
    vectors++; if (votes != 1) begin miscompares++; $display("FAIL basic_vote_count got %0d want 1", votes); end
    vectors++; if (ballots_cast !== 8'd1 || ready !== 1'b0) begin miscompares++; $display("FAIL basic_lockout cast %0d ready %b want 1/0", ballots_cast, ready); end
    drive(4'b0000);
    n = 0;
    while (selection !== 2'b11 && n < 20) begin
      tick(); n++;
      vectors++; if (dut_vec() !== mdl_vec() || ready !== 1'b0) begin miscompares++; $display("FAIL basic_release t=%0t got %h want %h", $time, dut_vec(), mdl_vec()); end
    end
    vectors++; if (selection !== 2'b11) begin miscompares++; $display("FAIL basic_exit selection got %b want 11", selection); end
  endtask

  task automatic test_glitch_and_reselect();
    int n, seen_inv;
    ballot_open = 1; tick(); ballot_open = 0;
    drive(4'b0001);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (dut_vec() !== mdl_vec()) begin miscompares++; $display("FAIL glitch t=%0t got %h want %h", $time, dut_vec(), mdl_vec()); end
    end
    drive(4'b0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++; if (dut_vec() !== mdl_vec()) begin miscompares++; $display("FAIL glitch_settle t=%0t got %h want %h", $time, dut_vec(), mdl_vec()); end
    end
    vectors++; if (selection !== 2'b11 || ready !== 1'b1) begin miscompares++; $display("FAIL glitch_ignored sel %b ready %b want 11/1", selection, ready); end
    drive(4'b0001);
    n = 0;
    while (selection !== 2'b00 && n < 20) begin
      tick(); n++;
      vectors++; if (dut_vec() !== mdl_vec()) begin miscompares++; $display("FAIL hold_a t=%0t got %h want %h", $time, dut_vec(), mdl_vec()); end
    end
    vectors++; if (selection !== 2'b00) begin miscompares++; $display("FAIL hold_a_select got %b want 00", selection); end
    drive(4'b0100);
    n = 0;
    while (selection !== 2'b10 && n < 20) begin
      tick(); n++;
      vectors++; if (dut_vec() !== mdl_vec()) begin miscompares++; $display("FAIL reselect_c t=%0t got %h want %h", $time, dut_vec(), mdl_vec()); end
    end
    vectors++; if (selection !== 2'b10) begin miscompares++; $display("FAIL reselect_c_value got %b want 10", selection); end
    drive(4'b0011);
    n = 0; seen_inv = 0;
    while (seen_inv == 0 && n < 12) begin
      tick(); n++;
      if (invalid_pulse === 1'b1) seen_inv = 1;
      vectors++; if (dut_vec() !== mdl_vec()) begin miscompares++; $display("FAIL multi_press t=%0t got %h want %h", $time, dut_vec(), mdl_vec()); end
    end
    vectors++; if (seen_inv != 1 || selection !== 2'b10) begin miscompares++; $display("FAIL invalid_pulse seen %0d sel %b want 1/10", seen_inv, selection); end
    tick();
    vectors++; if (invalid_pulse !== 1'b0) begin miscompares++; $display("FAIL invalid_one_cycle got %b want 0", invalid_pulse); end
    drive(4'b1000);
    n = 0;
    while (vote_enable !== 1'b1 && n < 12) begin
      tick(); n++;
      vectors++; if (dut_vec() !== mdl_vec()) begin miscompares++; $display("FAIL cast_c t=%0t got %h want %h", $time, dut_vec(), mdl_vec()); end
    end
    vectors++; if (vote_enable !== 1'b1 || vote_input !== 2'b10) begin miscompares++; $display("FAIL cast_c_vote en %b input %b want 1/10", vote_enable, vote_input); end
    drive(4'b0000);
    n = 0;
    while (selection !== 2'b11 && n < 20) begin
      tick(); n++;
      vectors++; if (dut_vec() !== mdl_vec()) begin miscompares++; $display("FAIL cast_c_release t=%0t got %h want %h", $time, dut_vec(), mdl_vec()); end
    end
  endtask

  task automatic test_timeout();
    int n, votes;
    ballot_open = 1; tick();
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL timeout_arm ready got %b want 1", ready); end
    n = 0; votes = 0;
    while (timeout_pulse !== 1'b1 && n < 40) begin
      tick(); n++;
      if (vote_enable === 1'b1) votes++;
      vectors++; if (dut_vec() !== mdl_vec()) begin miscompares++; $display("FAIL timeout_wait t=%0t got %h want %h", $time, dut_vec(), mdl_vec()); end
    end
    vectors++; if (n != T - 1) begin miscompares++; $display("FAIL timeout_latency got %0d want %0d", n, T - 1); end
    vectors++; if (selection !== 2'b11 || ready !== 1'b0 || votes != 0) begin miscompares++; $display("FAIL timeout_state sel %b ready %b votes %0d want 11/0/0", selection, ready, votes); end
    tick();
    vectors++; if (ready !== 1'b1 || timeout_pulse !== 1'b0) begin miscompares++; $display("FAIL rearm ready %b to %b want 1/0", ready, timeout_pulse); end
    drive(4'b0100);
    n = 0;
    while (selection !== 2'b10 && n < 20) begin
      tick(); n++;
      vectors++; if (dut_vec() !== mdl_vec()) begin miscompares++; $display("FAIL rearm_select t=%0t got %h want %h", $time, dut_vec(), mdl_vec()); end
    end
    drive(4'b1100);
    n = 0;
    while (vote_enable !== 1'b1 && n < 20) begin
      tick(); n++;
      vectors++; if (dut_vec() !== mdl_vec()) begin miscompares++; $display("FAIL rearm_cast t=%0t got %h want %h", $time, dut_vec(), mdl_vec()); end
    end
    vectors++; if (vote_enable !== 1'b1 || vote_input !== 2'b10) begin miscompares++; $display("FAIL rearm_vote en %b input %b want 1/10", vote_enable, vote_input); end
    ballot_open = 0; drive(4'b0000);
    n = 0;
    while (selection !== 2'b11 && n < 20) begin
      tick(); n++;
      vectors++; if (dut_vec() !== mdl_vec()) begin miscompares++; $display("FAIL rearm_release t=%0t got %h want %h", $time, dut_vec(), mdl_vec()); end
    end
  endtask

  task automatic test_random();
    logic [3:0] b;
    for (int i = 0; i < 3000; i++) begin
      b = {btn_cast, btn_c, btn_b, btn_a};
      for (int j = 0; j < 4; j++) if ($urandom_range(0, 7) == 0) b[j] = ~b[j];
      drive(b);
      if ($urandom_range(0, 9) == 0) ballot_open = ~ballot_open;
      tick();
      vectors++; if (dut_vec() !== mdl_vec()) begin miscompares++; $display("FAIL random cyc %0d got %h want %h", i, dut_vec(), mdl_vec()); end
    end
    drive(4'b0000); ballot_open = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      vectors++; if (dut_vec() !== mdl_vec()) begin miscompares++; $display("FAIL random_drain cyc %0d got %h want %h", i, dut_vec(), mdl_vec()); end
    end
  endtask

  task automatic test_wrap();
    int n, c;
    logic [3:0] cand;
    reset = 1; tick(); reset = 0;
    for (int k = 0; k < 256; k++) begin
      c = $urandom_range(0, 2);
      cand = 4'b0001 << c;
      ballot_open = 1; tick(); ballot_open = 0;
      drive(cand);
      n = 0;
      while (selection === 2'b11 && n < 20) begin
        tick(); n++;
        vectors++; if (dut_vec() !== mdl_vec()) begin miscompares++; $display("FAIL wrap_select s%0d got %h want %h", k, dut_vec(), mdl_vec()); end
      end
      drive(cand | 4'b1000);
      n = 0;
      while (vote_enable !== 1'b1 && n < 20) begin
        tick(); n++;
        vectors++; if (dut_vec() !== mdl_vec()) begin miscompares++; $display("FAIL wrap_cast s%0d got %h want %h", k, dut_vec(), mdl_vec()); end
      end
      vectors++; if (vote_input !== 2'(c) || ballots_cast !== 8'((k + 1) % 256)) begin
        miscompares++; $display("FAIL wrap_vote s%0d input %b count %0d want %0d/%0d", k, vote_input, ballots_cast, c, (k + 1) % 256);
      end
      drive(4'b0000);
      n = 0;
      while (selection !== 2'b11 && n < 20) begin
        tick(); n++;
        vectors++; if (dut_vec() !== mdl_vec()) begin miscompares++; $display("FAIL wrap_release s%0d got %h want %h", k, dut_vec(), mdl_vec()); end
      end
    end
    vectors++; if (ballots_cast !== 8'd0) begin miscompares++; $display("FAIL wrap_final got %0d want 0", ballots_cast); end
  endtask

  task automatic test_reset_mid();
    int n, votes;
    ballot_open = 1; tick(); ballot_open = 0;
    drive(4'b0001);
    n = 0;
    while (selection !== 2'b00 && n < 20) begin tick(); n++; end
    vectors++; if (selection !== 2'b00 || ready !== 1'b1) begin miscompares++; $display("FAIL midreset_setup sel %b ready %b want 00/1", selection, ready); end
    drive(4'b1001);
    tick(); tick(); tick();
    #2 reset = 1;
    #1;
    vectors++; if (dut_vec() !== RST_VEC) begin miscompares++; $display("FAIL midreset_async got %h want %h", dut_vec(), RST_VEC); end
    drive(4'b0000);
    tick();
    reset = 0;
    votes = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (vote_enable === 1'b1) votes++;
      vectors++; if (dut_vec() !== mdl_vec() || dut_vec() !== RST_VEC) begin miscompares++; $display("FAIL midreset_after got %h want %h", dut_vec(), RST_VEC); end
    end
    vectors++; if (votes != 0) begin miscompares++; $display("FAIL midreset_no_vote got %0d want 0", votes); end
  endtask

  initial begin
    model_reset();
    reset = 1; ballot_open = 0; drive(4'b0000);
    test_reset();
    test_basic_vote();
    test_glitch_and_reselect();
    test_timeout();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ballot_controller.md
Name: ballot_controller

Overview:
- Front-end stage that converts raw voter push-buttons into clean, one-per-voter vote commands for the vote counter.
- Synchronises and debounces the A/B/C/cast buttons, and enforces officer-authorised single-ballot sessions with a timeout.
- Drives vote_input/vote_enable straight into the downstream tally block's identically named inputs.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed before a debounced level changes (>=1)
TIMEOUT_CYCLES, 1000, maximum cycles a session may stay in ARMED/SELECTED with no accepted press (>=2)
TMR_W, 16, timer width; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ballot_open  in  1  officer authorise, sampled level; acted on only in IDLE
btn_a  in  1  raw candidate A button, asynchronous, active-high
btn_b  in  1  raw candidate B button
btn_c  in  1  raw candidate C button
btn_cast  in  1  raw cast/confirm button
vote_input  out  2  candidate code to tally: A=00, B=01, C=10; 11 when idle
vote_enable  out  1  one-cycle strobe, qualifies vote_input
ready  out  1  high in ARMED or SELECTED (voter may act)
selection  out  2  currently selected code; 11 = none
timeout_pulse  out  1  one-cycle strobe when a session expires without a cast
invalid_pulse  out  1  one-cycle strobe when a multi-button press is rejected
ballots_cast  out  8  count of vote_enable strobes; wraps 255->0

Behaviour:
- Reset (async): state=IDLE; vote_input=11, vote_enable=0, ready=0, selection=11, timeout_pulse=0, invalid_pulse=0, ballots_cast=0; synchronisers, debounced levels, debounce counters and timer all 0.
- Input conditioning, per button:
  - 2-flop synchroniser.
  - Debounced level flips on the cycle after the synchronised value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing sample clears the counter.
  - Raw edge to debounced edge = 2 + DEBOUNCE_CYCLES cycles.
  - "press" = debounced 0->1 edge (one cycle).
- FSM:
  - IDLE: ballot_open=1 -> ARMED; timer cleared.
  - ARMED:
    - exactly one candidate press this cycle -> SELECTED; selection=code.
    - two or more candidate presses in the same cycle -> invalid_pulse, stay ARMED.
    - cast press -> ignored.
  - SELECTED:
    - a single new candidate press replaces selection; the timer restarts.
    - multi-press -> invalid_pulse; selection unchanged.
    - cast press -> CAST.
    - If a candidate press and a cast press land in the same cycle, the cast wins using the old selection.
  - CAST (1 cycle): vote_enable=1, vote_input=selection, ballots_cast+1 -> LOCKOUT.
  - LOCKOUT: ready=0; stays until all four debounced levels are 0 -> IDLE; selection returns to 11 on exit.
- Timeout:
  - The timer counts every cycle in ARMED/SELECTED and restarts on each accepted press.
  - Reaching TIMEOUT_CYCLES-1 -> timeout_pulse for one cycle, selection=11 -> IDLE; no vote is issued.
- Outputs: vote_input=11 whenever vote_enable=0. Exactly one vote_enable per session; ballot_open held high does not re-arm until the session returns to IDLE.
- Reset mid-session: the session is abandoned and no vote_enable is issued; the following cycle is a full reset state.
- All outputs are registered.

Test Plan:
- Reset, DEBOUNCE_CYCLES=4: ballot_open=1 for 1 cycle; btn_b high from cycle 10 -> SELECTED, selection=01 at cycle 16 (10+2+4); btn_cast high -> single vote_enable with vote_input=01; ballots_cast=1; ready=0 until all buttons released.
- btn_a glitch high for 3 cycles then low -> no selection change. Held 4+ cycles -> selection=00.
- In SELECTED(A): press C, then cast -> vote_input=10. btn_a and btn_b rise in the same cycle -> invalid_pulse=1 for one cycle, selection unchanged.
- TIMEOUT_CYCLES=20: arm, no press -> timeout_pulse at cycle 19 after arming, state IDLE, no vote_enable. Keep ballot_open high -> re-arms, then a vote completes normally.
- 256 complete sessions -> ballots_cast wraps to 0. Assert reset during SELECTED -> all outputs at reset values, no vote_enable, ready=0.
